// File: rtl/dpath_seq_pkg.sv
// Shared types and constants for the dpath command sequencer.
// The dpath constants SEL_W, DATA_W and COM_NOP come from def.h, which is
// shared with dpath. The guarded defaults below let this slice build on its
// own; a def.h included ahead of this file takes precedence.
// Contents:
//   SEL_W / DATA_W / CNT_W : widths of command code, operand and repeat count
//   COM_NOP                : command code driven when nothing is issuing
//   cmd_t                  : one queued command word {cnt, com, data}
//   state_t                : sequencer FSM states
`ifndef SEL_W
`define SEL_W 3
`endif
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef COM_NOP
`define COM_NOP {`SEL_W{1'b0}}
`endif

package dpath_seq_pkg;

  localparam int SEL_W  = `SEL_W;
  localparam int DATA_W = `DATA_W;
  localparam int CNT_W  = 4;

  localparam logic [SEL_W-1:0] COM_NOP = `COM_NOP;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  com;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // IDLE: no current word; RUN: current word, not stalled; HOLD: stalled
  // with a current word parked.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/dpath_seq_if.sv
// Upstream command handshake into the sequencer.
// Signals:
//   in_valid : upstream word valid        (master -> slave)
//   in_ready : sequencer can take a word  (slave  -> master)
//   in_cnt   : repeat count, word issues in_cnt+1 times
//   in_com   : dpath command code
//   in_data  : dpath operand
interface dpath_seq_if;
  import dpath_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  in_cnt;
  logic [SEL_W-1:0]  in_com;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid, in_cnt, in_com, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_cnt, in_com, in_data,
    output in_ready
  );
endinterface

// File: rtl/dpath_seq_cmd_fifo.sv
// cmd_fifo: DEPTH-entry first-word-fall-through command FIFO.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_wdata : write a word (ignored when full)
//   i_pop           : drop the head word (ignored when empty)
//   o_full, o_empty : occupancy flags from registered pointers only
//   o_head          : word at the read pointer, valid when !o_empty
module cmd_fifo
  import dpath_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  // One bit wider than the index: equal index with differing top bit is full.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/dpath_seq.sv
// dpath_seq: queues command words and replays each one cnt+1 times onto the
// dpath com/datain inputs, honouring a downstream stall.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   up       : upstream command handshake (dpath_seq_if.slave)
//   stall    : downstream hold request; freezes the sequence for that edge
//   com      : registered dpath command code (COM_NOP when idle/stalled)
//   datain   : registered dpath operand (holds its value when not issuing)
//   issue    : com/datain carry a live command this cycle
//   busy     : work queued, in progress, or currently issuing
module dpath_seq
  import dpath_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  dpath_seq_if.slave        up,
  input  logic              stall,
  output logic [SEL_W-1:0]  com,
  output logic [DATA_W-1:0] datain,
  output logic              issue,
  output logic              busy
);

  state_t            r_state,    w_state_nxt;
  logic [SEL_W-1:0]  r_cur_com,  w_cur_com_nxt;
  logic [DATA_W-1:0] r_cur_data, w_cur_data_nxt;
  logic [CNT_W-1:0]  r_rem,      w_rem_nxt;
  logic [SEL_W-1:0]  r_com,      w_com_nxt;
  logic [DATA_W-1:0] r_datain,   w_datain_nxt;
  logic              r_issue,    w_issue_nxt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_cur_v;
  cmd_t w_head;
  cmd_t w_wcmd;

  assign w_wcmd  = '{cnt: up.in_cnt, com: up.in_com, data: up.in_data};
  // Ready looks only at registered fullness, so a same-cycle pop never
  // opens a slot combinationally.
  assign up.in_ready = !w_full;
  assign w_push      = up.in_valid && !w_full;
  assign w_cur_v     = (r_state != ST_IDLE);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wcmd),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // NOTE: every signal written here gets a hold/default value first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_com_nxt  = r_cur_com;
    w_cur_data_nxt = r_cur_data;
    w_rem_nxt      = r_rem;
    w_com_nxt      = r_com;
    w_datain_nxt   = r_datain;
    w_issue_nxt    = r_issue;
    w_pop          = 1'b0;

    if (stall) begin
      // Freeze everything except the live outputs; IDLE stays IDLE.
      w_com_nxt   = COM_NOP;
      w_issue_nxt = 1'b0;
      if (r_state == ST_RUN) w_state_nxt = ST_HOLD;
    end else if (w_cur_v && (r_rem != '0)) begin
      w_com_nxt    = r_cur_com;
      w_datain_nxt = r_cur_data;
      w_issue_nxt  = 1'b1;
      w_rem_nxt    = r_rem - 1'b1;
      w_state_nxt  = ST_RUN;
    end else if (!w_empty) begin
      // Current word exhausted (or none): the head issues on this same edge,
      // which is what keeps consecutive words bubble-free.
      w_pop          = 1'b1;
      w_cur_com_nxt  = w_head.com;
      w_cur_data_nxt = w_head.data;
      w_rem_nxt      = w_head.cnt;
      w_com_nxt      = w_head.com;
      w_datain_nxt   = w_head.data;
      w_issue_nxt    = 1'b1;
      w_state_nxt    = ST_RUN;
    end else begin
      w_com_nxt   = COM_NOP;
      w_issue_nxt = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_com  <= COM_NOP;
      r_cur_data <= '0;
      r_rem      <= '0;
      r_com      <= COM_NOP;
      r_datain   <= '0;
      r_issue    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_com  <= w_cur_com_nxt;
      r_cur_data <= w_cur_data_nxt;
      r_rem      <= w_rem_nxt;
      r_com      <= w_com_nxt;
      r_datain   <= w_datain_nxt;
      r_issue    <= w_issue_nxt;
    end
  end

  assign com    = r_com;
  assign datain = r_datain;
  assign issue  = r_issue;
  assign busy   = !w_empty || w_cur_v || r_issue;

endmodule

// File: tb/tb_dpath_seq.sv
// Self-checking bench for dpath_seq. The reference model is a queue of the
// (com, data) pairs still owed to dpath, in issue order; each entry marks
// whether it is the first issue of its word, so the number of such entries
// is the number of words still sitting in the FIFO.
module tb_dpath_seq;
  import dpath_seq_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [SEL_W-1:0]  com;
    logic [DATA_W-1:0] data;
    bit                first;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [SEL_W-1:0]  com;
  logic [DATA_W-1:0] datain;
  logic              issue;
  logic              busy;

  dpath_seq_if u_if ();

  dpath_seq #(.DEPTH(DEPTH)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .up     (u_if.slave),
    .stall  (stall),
    .com    (com),
    .datain (datain),
    .issue  (issue),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t              exp_q[$];
  logic [SEL_W-1:0]  m_com;
  logic [DATA_W-1:0] m_datain;
  bit                m_cur_v;
  bit                m_issue;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fifo_words();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].first) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_com    = COM_NOP;
    m_datain = '0;
    m_cur_v  = 0;
    m_issue  = 0;
  endtask

  // One clock: drive inputs, check ready, take the edge, advance the model,
  // then check the registered outputs 1 time unit later.
  task automatic step(input logic v, input logic [CNT_W-1:0] c,
                      input logic [SEL_W-1:0] cm, input logic [DATA_W-1:0] d,
                      input logic st, output bit acc);
    bit   ready_exp;
    exp_t e;
    u_if.in_valid = v;
    u_if.in_cnt   = c;
    u_if.in_com   = cm;
    u_if.in_data  = d;
    stall         = st;
    ready_exp = (fifo_words() < DEPTH);
    check("in_ready", 32'(u_if.in_ready), 32'(ready_exp));
    acc = v && ready_exp;
    @(posedge clk);
    if (!st) begin
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        m_issue  = 1;
        m_com    = e.com;
        m_datain = e.data;
        m_cur_v  = 1;
      end else begin
        m_issue = 0;
        m_com   = COM_NOP;
        m_cur_v = 0;
      end
    end else begin
      m_issue = 0;
      m_com   = COM_NOP;
    end
    if (acc) begin
      for (int k = 0; k <= int'(c); k++) exp_q.push_back('{cm, d, k == 0});
    end
    #1;
    check("issue",  32'(issue),  32'(m_issue));
    check("com",    32'(com),    32'(m_com));
    check("datain", 32'(datain), 32'(m_datain));
    check("busy",   32'(busy),   32'((fifo_words() > 0) || m_cur_v || m_issue));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_com"},   32'(com),           32'(COM_NOP));
    check({tag, "_data"},  32'(datain),        32'h0);
    check({tag, "_issue"}, 32'(issue),         32'h0);
    check({tag, "_ready"}, 32'(u_if.in_ready), 32'h1);
    check({tag, "_busy"},  32'(busy),          32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    int guard;

    // Reset is asynchronous: outputs must be at reset values before any edge.
    rst           = 1'b1;
    stall         = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_cnt   = '0;
    u_if.in_com   = '0;
    u_if.in_data  = '0;
    model_reset();
    #3;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single word, cnt=0: one issue after the next edge, then NOP.
    step(1'b1, 4'd0, 3'b001, 16'h2222, 1'b0, acc);
    check("single_acc", 32'(acc), 32'h1);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    check("lat_issue", 32'(issue),  32'h1);
    check("lat_com",   32'(com),    32'h1);
    check("lat_data",  32'(datain), 32'h2222);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    check("after_issue", 32'(issue), 32'h0);
    check("after_data",  32'(datain), 32'h2222);
    idle(2);

    // Back-to-back words: 3x 110/3333 then 111/1111 with no bubble.
    step(1'b1, 4'd2, 3'b110, 16'h3333, 1'b0, acc);
    step(1'b1, 4'd0, 3'b111, 16'h1111, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    check("b2b_com",  32'(com),    32'h7);
    check("b2b_data", 32'(datain), 32'h1111);
    idle(3);

    // Stall while offering five words: four fit, the fifth waits.
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 4'd0, 3'b010, 16'h4440 + 16'(idx), 1'b1, acc);
      if (acc) idx++;
    end
    check("stall_accepted", 32'(idx), 32'd4);
    check("stall_full", 32'(u_if.in_ready), 32'h0);
    guard = 0;
    while (idx < 5 && guard < 20) begin
      step(1'b1, 4'd0, 3'b010, 16'h4440 + 16'(idx), 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    check("fifth_accepted", 32'(idx), 32'd5);
    idle(8);

    // Repeat word with a two-edge stall after its second issue.
    step(1'b1, 4'd3, 3'b110, 16'h1234, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    check("rep_2nd", 32'(issue), 32'h1);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    check("rep_hold_busy", 32'(busy), 32'h1);
    idle(4);

    // Reset mid-repeat with words queued.
    step(1'b1, 4'd3, 3'b011, 16'hA001, 1'b0, acc);
    step(1'b1, 4'd3, 3'b100, 16'hA002, 1'b0, acc);
    step(1'b1, 4'd3, 3'b101, 16'hA003, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), CNT_W'($urandom_range(0, 3)),
           SEL_W'($urandom), DATA_W'($urandom),
           1'($urandom_range(0, 3) == 0), acc);
    end
    guard = 0;
    while ((exp_q.size() > 0 || m_cur_v) && guard < 300) begin
      step(1'b0, '0, '0, '0, 1'b0, acc);
      guard++;
    end
    check("drain_bound", 32'(guard < 300), 32'h1);
    check("drain_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dpath_seq.md
DPATH_SEQ -- requirements
Module: dpath_seq

Interface
REQ-001 Parameter DEPTH, default 4, sets the command FIFO depth in entries (power of two, at least 2).
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port in_valid, input, 1 bit: upstream command word is valid.
REQ-005 Port in_ready, output, 1 bit: block can accept a command word.
REQ-006 Port in_cnt, input, 4 bits: repeat count; the word issues in_cnt+1 times.
REQ-007 Port in_com, input, `SEL_W bits: dpath command code.
REQ-008 Port in_data, input, `DATA_W bits: dpath operand.
REQ-009 Port stall, input, 1 bit: downstream hold request.
REQ-010 Port com, output, `SEL_W bits: drives dpath com.
REQ-011 Port datain, output, `DATA_W bits: drives dpath datain.
REQ-012 Port issue, output, 1 bit: com/datain carry a live command this cycle.
REQ-013 Port busy, output, 1 bit: work is queued or in progress.

Function
REQ-014 A word {in_cnt, in_com, in_data} SHALL be written to the FIFO on each rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL equal NOT full, computed from registered FIFO state; it SHALL be 0 when full even if a pop occurs in the same cycle.
REQ-016 The block SHALL hold current-word registers cur_com, cur_data, rem (4 bits) and cur_v.
REQ-017 FSM states: IDLE (cur_v=0), RUN (cur_v=1, not stalled), HOLD (cur_v=1, stalled).
REQ-018 On an edge with stall=1, the block SHALL set com<=`COM_NOP and issue<=0; rem, cur_*, datain and FIFO read state SHALL be unchanged; RUN goes to HOLD and IDLE stays IDLE.
REQ-019 On an edge with stall=0, cur_v=1 and rem>0, the block SHALL set com<=cur_com, datain<=cur_data, issue<=1 and rem<=rem-1.
REQ-020 On an edge with stall=0 and (cur_v=0 or rem=0), if the FIFO is non-empty the block SHALL pop the head, load cur_* from it, set rem<=head.cnt, drive com/datain from the head, and set issue<=1 and cur_v<=1.
REQ-021 On an edge with stall=0, (cur_v=0 or rem=0) and an empty FIFO, the block SHALL set com<=`COM_NOP, issue<=0 and cur_v<=0, and datain SHALL hold its last value.
REQ-022 Consecutive words SHALL issue back-to-back with no bubble cycle between them.
REQ-023 Latency: a word accepted at edge N into an empty FIFO with IDLE and stall=0 SHALL appear with issue=1 after edge N+1.
REQ-024 A push and a pop in the same cycle SHALL both take effect when the FIFO is not full.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-026 busy SHALL be 1 whenever the FIFO is non-empty, cur_v=1, or issue=1.
REQ-027 Words SHALL issue in acceptance order, and no word may be dropped or duplicated beyond its in_cnt+1 issues.

Reset
REQ-028 While rst=1 the block SHALL force com=`COM_NOP, datain=0, issue=0, cur_v=0, rem=0, FIFO empty, in_ready=1 and busy=0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-progress words; operation resumes from IDLE on the first edge after rst falls.

Structure
REQ-030 `SEL_W, `DATA_W and the new constant `COM_NOP (`SEL_W'b000) SHALL reside in def.h, shared with dpath.
REQ-031 The FIFO SHALL be a sub-module named cmd_fifo (DEPTH-parameterised, push/pop/full/empty/head); the FSM and issue registers SHALL reside in dpath_seq.
REQ-032 The outputs com, datain and issue SHALL be registered and SHALL connect directly to dpath com and datain.

Verification
REQ-033 Reset: rst=1 -> com=000, datain=0000, issue=0, in_ready=1, busy=0.
REQ-034 Single word cnt=0, com=001, data=2222 -> exactly one issue cycle with com=001 and datain=2222, then com=000 and issue=0.
REQ-035 Words (cnt=2, 110, 3333) then (cnt=0, 111, 1111) -> three consecutive issue cycles of 110/3333, immediately followed by one cycle of 111/1111 with no bubble.
REQ-036 stall=1 while offering 5 words (cnt=0, data=4440..4444) -> 4 words accepted, then in_ready=0 with the 5th held; on stall=0 -> 4440..4443 issue in order, then 4444 is accepted and issued.
REQ-037 Word cnt=3, com=110, data=1234, with stall=1 for 2 edges after the 2nd issue -> issue=0 for 2 cycles, then exactly 2 more issues (4 in total).
REQ-038 Three words queued and rst pulsed mid-repeat -> outputs at reset values immediately, FIFO empty, and no queued word issues after rst falls.
